// File: rtl/id_issue_queue.sv
// Instruction queue between fetch and decode: up to FETCH_W writes, up to ISSUE_W oldest reads per cycle.
// Latency: an entry is visible at the outputs one cycle after it is enqueued. Outputs are combinational from head.
// Backpressure: in_ready drops when fewer than FETCH_W slots are free. ID_DSLOT_HOLD_EN holds a branch until its delay slot arrives.
module id_issue_queue #(
    parameter int DEPTH   = 16,
    parameter int FETCH_W = 2,
    parameter int ISSUE_W = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic [FETCH_W-1:0]       in_valid,
    input  logic [32*FETCH_W-1:0]    in_pc,
    input  logic [32*FETCH_W-1:0]    in_inst,
    output logic                     in_ready,
    output logic [ISSUE_W-1:0]       out_valid,
    output logic [32*ISSUE_W-1:0]    out_pc,
    output logic [32*ISSUE_W-1:0]    out_inst,
    input  logic [ISSUE_W-1:0]       out_accept,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
    localparam logic [PW-1:0] FETCH_P = PW'(FETCH_W);
    localparam logic [PW-1:0] ISSUE_P = PW'(ISSUE_W);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } entry_t;

    entry_t        mem [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [PW-1:0] n_in;
    logic [PW-1:0] n_out;
    logic [PW-1:0] n_cand;
    logic [PW-1:0] n_vld;
    logic          enq;
    entry_t        rd_ent [ISSUE_W];

    // Extra pointer MSB distinguishes full from empty, so the difference is the occupancy.
    assign count    = tail - head;
    assign in_ready = !rst && ((DEPTH_P - count) >= FETCH_P);
    assign enq      = (|in_valid) && in_ready && !flush;

    always_comb begin
        n_in = '0;
        for (int i = 0; i < FETCH_W; i++) begin
            n_in = n_in + PW'(in_valid[i]);
        end
        n_out = '0;
        for (int k = 0; k < ISSUE_W; k++) begin
            n_out = n_out + PW'(out_accept[k]);
        end
    end

    always_comb begin
        for (int k = 0; k < ISSUE_W; k++) begin
            rd_ent[k] = mem[head[AW-1:0] + AW'(k)];
        end
    end

`ifdef ID_DSLOT_HOLD_EN
    function automatic logic is_branch(input logic [31:0] inst);
        logic [5:0] op;
        logic [5:0] func;
        op   = inst[31:26];
        func = inst[5:0];
        return ((op >= 6'd1) && (op <= 6'd7)) ||
               ((op == 6'd0) && ((func == 6'd8) || (func == 6'd9)));
    endfunction

    logic [ISSUE_W-1:0] lane_br;

    always_comb begin
        for (int k = 0; k < ISSUE_W; k++) begin
            lane_br[k] = is_branch(rd_ent[k].inst);
        end
    end
`endif

    always_comb begin
        n_cand = (count < ISSUE_P) ? count : ISSUE_P;
        n_vld  = n_cand;
`ifdef ID_DSLOT_HOLD_EN
        // Youngest candidate is a branch whose slot has not been fetched yet: keep it back.
        for (int k = 0; k < ISSUE_W; k++) begin
            if ((PW'(k + 1) == n_cand) && (count == n_cand) && lane_br[k]) begin
                n_vld = n_cand - PW'(1);
            end
        end
`endif
        if (rst) begin
            n_vld = '0;
        end
    end

    always_comb begin
        out_valid = '0;
        out_pc    = '0;
        out_inst  = '0;
        for (int k = 0; k < ISSUE_W; k++) begin
            out_valid[k]        = (PW'(k) < n_vld);
            out_pc[32*k +: 32]   = rd_ent[k].pc;
            out_inst[32*k +: 32] = rd_ent[k].inst;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head <= '0;
            tail <= '0;
        end else begin
            head <= head + n_out;
            if (enq) begin
                tail <= tail + n_in;
            end
        end
    end

    // Payload storage carries no reset; occupancy is tracked by the pointers alone.
    always_ff @(posedge clk) begin
        if (enq) begin
            for (int i = 0; i < FETCH_W; i++) begin
                if (in_valid[i]) begin
                    mem[tail[AW-1:0] + AW'(i)] <= '{pc: in_pc[32*i +: 32], inst: in_inst[32*i +: 32]};
                end
            end
        end
    end

endmodule

// File: tb/tb_id_issue_queue.sv
// Scoreboard bench for id_issue_queue: directed scenarios followed by random enqueue/dequeue traffic.
module tb_id_issue_queue;

    localparam int DEPTH = 16;
    localparam int FW    = 2;
    localparam int IW    = 2;
    localparam logic [31:0] ADDIU = 32'h24010001;
    localparam logic [31:0] BEQ   = 32'h10220003;
    localparam logic [31:0] JR    = 32'h03E00008;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic [FW-1:0] in_valid;
    logic [63:0]   in_pc;
    logic [63:0]   in_inst;
    logic          in_ready;
    logic [IW-1:0] out_valid;
    logic [63:0]   out_pc;
    logic [63:0]   out_inst;
    logic [IW-1:0] out_accept;
    logic [4:0]    count;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;
    ent_t sb[$];
    logic [31:0] pc_ctr;

    id_issue_queue #(.DEPTH(DEPTH), .FETCH_W(FW), .ISSUE_W(IW)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_pc      (in_pc),
        .in_inst    (in_inst),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_pc     (out_pc),
        .out_inst   (out_inst),
        .out_accept (out_accept),
        .count      (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit is_br(input logic [31:0] i);
        logic [5:0] op;
        op = i[31:26];
        return ((op >= 6'd1) && (op <= 6'd7)) || ((op == 6'd0) && ((i[5:0] == 6'd8) || (i[5:0] == 6'd9)));
    endfunction

    function automatic int exp_nvld();
        int n;
        n = (sb.size() < IW) ? sb.size() : IW;
`ifdef ID_DSLOT_HOLD_EN
        if ((n > 0) && (sb.size() == n) && is_br(sb[n-1].inst)) n--;
`endif
        if (rst) n = 0;
        return n;
    endfunction

    task automatic check_outs();
        int n;
        n = exp_nvld();
        chk("count", 32'(count), sb.size());
        chk("in_ready", 32'(in_ready), (!rst && (sb.size() <= DEPTH - FW)) ? 1 : 0);
        chk("out_valid", 32'(out_valid), (1 << n) - 1);
        for (int k = 0; k < n; k++) begin
            chk("out_pc", out_pc[32*k +: 32], sb[k].pc);
            chk("out_inst", out_inst[32*k +: 32], sb[k].inst);
        end
    endtask

    // Called at a negedge: drive one cycle, advance the model at the posedge, check at the next negedge.
    task automatic step(input logic [1:0] v, input logic [31:0] pc0, input logic [31:0] i0,
                        input logic [31:0] i1, input logic [1:0] acc, input logic fl, input logic r);
        bit rdy;
        int nout;
        in_valid   = v;
        in_pc      = {pc0 + 32'd4, pc0};
        in_inst    = {i1, i0};
        out_accept = acc;
        flush      = fl;
        rst        = r;
        assert (((acc & ~out_valid) == 2'b00) && (acc != 2'b10)) else $error("out_accept not a prefix of out_valid");
        rdy  = !r && (sb.size() <= DEPTH - FW);
        nout = int'(acc[0]) + int'(acc[1]);
        @(posedge clk);
        if (r || fl) begin
            sb.delete();
        end else begin
            for (int i = 0; i < nout; i++) void'(sb.pop_front());
            if (rdy && v[0]) sb.push_back('{pc: pc0, inst: i0});
            if (rdy && v[1]) sb.push_back('{pc: pc0 + 32'd4, inst: i1});
        end
        @(negedge clk);
        check_outs();
    endtask

    function automatic logic [31:0] pick_inst();
        case ($urandom_range(0, 3))
            0:       return BEQ;
            1:       return JR;
            default: return {6'h09, 26'($urandom)};
        endcase
    endfunction

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = '0; in_pc = '0; in_inst = '0; out_accept = '0;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        step(2'b00, 0, 0, 0, 2'b00, 1'b0, 1'b1);
        step(2'b00, 0, 0, 0, 2'b00, 1'b0, 1'b0);
        chk("post_rst_count", 32'(count), 0);
        chk("post_rst_ready", 32'(in_ready), 1);

        // First pair issues one cycle after enqueue, oldest in lane 0.
        step(2'b11, 32'hBFC00000, ADDIU, ADDIU, 2'b00, 1'b0, 1'b0);
        chk("t1_count", 32'(count), 2);
        chk("t1_valid", 32'(out_valid), 3);
        chk("t1_pc0", out_pc[31:0], 32'hBFC00000);
        chk("t1_pc1", out_pc[63:32], 32'hBFC00004);

        // Fill to full, then check freed slots are not reused in the same cycle, then wrap.
        pc_ctr = 32'hBFC00008;
        for (int i = 0; i < 7; i++) begin
            step(2'b11, pc_ctr, ADDIU, ADDIU, 2'b00, 1'b0, 1'b0);
            pc_ctr += 32'd8;
        end
        chk("t2_full_count", 32'(count), 16);
        chk("t2_full_ready", 32'(in_ready), 0);
        step(2'b11, pc_ctr, ADDIU, ADDIU, 2'b11, 1'b0, 1'b0);
        chk("t2_drop_count", 32'(count), 14);
        step(2'b11, pc_ctr, ADDIU, ADDIU, 2'b11, 1'b0, 1'b0);
        pc_ctr += 32'd8;
        chk("t2_wrap_count", 32'(count), 14);
        for (int i = 0; i < 7; i++) step(2'b00, 0, 0, 0, 2'b11, 1'b0, 1'b0);
        chk("t2_drain_count", 32'(count), 0);

        // Branch with and without its delay slot.
        step(2'b01, 32'h00000100, BEQ, 0, 2'b00, 1'b0, 1'b0);
`ifdef ID_DSLOT_HOLD_EN
        chk("t3_beq_held", 32'(out_valid), 0);
`else
        chk("t3_beq_alone", 32'(out_valid), 1);
`endif
        step(2'b01, 32'h00000104, ADDIU, 0, 2'b00, 1'b0, 1'b0);
        chk("t3_pair_valid", 32'(out_valid), 3);
        chk("t3_pair_pc0", out_pc[31:0], 32'h00000100);
        step(2'b00, 0, 0, 0, 2'b11, 1'b0, 1'b0);

        // Flush wins over enqueue and accept.
        step(2'b11, 32'h00000200, ADDIU, ADDIU, 2'b00, 1'b0, 1'b0);
        step(2'b11, 32'h00000208, ADDIU, ADDIU, 2'b01, 1'b1, 1'b0);
        chk("t4_count", 32'(count), 0);
        chk("t4_valid", 32'(out_valid), 0);
        chk("t4_ready", 32'(in_ready), 1);

        // Reset mid-stream at count 7.
        step(2'b11, 32'h00000300, ADDIU, ADDIU, 2'b00, 1'b0, 1'b0);
        step(2'b11, 32'h00000308, ADDIU, ADDIU, 2'b00, 1'b0, 1'b0);
        step(2'b11, 32'h00000310, ADDIU, ADDIU, 2'b00, 1'b0, 1'b0);
        step(2'b01, 32'h00000318, ADDIU, ADDIU, 2'b00, 1'b0, 1'b0);
        chk("t5_pre_count", 32'(count), 7);
        step(2'b11, 32'h00000320, ADDIU, ADDIU, 2'b00, 1'b0, 1'b1);
        chk("t5_rst_count", 32'(count), 0);
        chk("t5_rst_ready", 32'(in_ready), 0);
        step(2'b11, 32'h00000400, ADDIU, ADDIU, 2'b00, 1'b0, 1'b0);
        chk("t5_refill_count", 32'(count), 2);
        chk("t5_refill_pc0", out_pc[31:0], 32'h00000400);

        // Random traffic against the scoreboard.
        pc_ctr = 32'h80000000;
        for (int c = 0; c < 10000; c++) begin
            int n;
            int k;
            int vk;
            logic [1:0] acc;
            logic [1:0] v;
            n   = exp_nvld();
            k   = int'($urandom_range(0, n));
            acc = 2'((1 << k) - 1);
            vk  = int'($urandom_range(0, 2));
            v   = 2'((1 << vk) - 1);
            step(v, pc_ctr, pick_inst(), pick_inst(), acc, ($urandom_range(0, 199) == 0), 1'b0);
            pc_ctr += 32'd8;
            chk("count_le_depth", 32'(count <= 5'd16), 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
